// File: rtl/serial_frame_sequencer.sv
// Bus-mapped serial frame sequencer: window decode, TX/RX/XCHG frames on sck/sdo/sdi, readback.
// Optional LSB-first frame order is compiled in when SERSEQ_LSB_FIRST_EN is defined.
module serial_frame_sequencer #(
  parameter int unsigned ADDR_W  = 14,
  parameter logic [1:0]  SEL_HI  = 2'b01,
  parameter int unsigned FRAME_W = 16,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               sser_i,
  input  logic [ADDR_W-1:0]  ba_i,
  input  logic               br_w_i,
  input  logic [FRAME_W-1:0] din_i,
  output logic [FRAME_W-1:0] dout_o,
  output logic               dout_oe_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               sck_o,
  output logic               sdo_o,
  output logic               sdo_oe_o,
  input  logic               sdi_i
);
  localparam int unsigned BitW  = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int unsigned HalfW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BitW-1:0]  BitLast  = BitW'(FRAME_W - 1);
  localparam logic [HalfW-1:0] HalfLast = HalfW'(CLK_DIV - 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StLow  = 3'd2;
  localparam logic [2:0] StHigh = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic [BitW-1:0]    bit_q, bit_d;
  logic [HalfW-1:0]   half_q, half_d;
  logic               sticky_q, sticky_d;
  logic               sdo_q, sdo_d;
  logic               lsb_q, lsb_d;

  logic               sel, wr_en, rd_en, start, abort;
  logic               rx_bit, out_bit, lsb_req;
  logic [FRAME_W-1:0] shift_nxt;
  logic [FRAME_W-1:0] status;

  assign sel   = ~sser_i & (ba_i[ADDR_W-1:ADDR_W-2] == SEL_HI);
  assign wr_en = sel & ~br_w_i;
  assign rd_en = sel & br_w_i;
  assign start = wr_en & ba_i[7] & ~ba_i[6] & (ba_i[5:4] != 2'b00);
  assign abort = wr_en & ba_i[6];

  // Receive bit is zero for TX-only frames so the shifter just drains.
  assign rx_bit = mode_q[1] & sdi_i;

`ifdef SERSEQ_LSB_FIRST_EN
  assign lsb_req   = ba_i[3];
  assign shift_nxt = lsb_q ? {rx_bit, shift_q[FRAME_W-1:1]} : {shift_q[FRAME_W-2:0], rx_bit};
  assign out_bit   = lsb_q ? shift_q[0] : shift_q[FRAME_W-1];
  logic unused_ba;
  assign unused_ba = ^{ba_i[ADDR_W-3:8], ba_i[2:0]};
`else
  assign lsb_req   = 1'b0;
  assign shift_nxt = {shift_q[FRAME_W-2:0], rx_bit};
  assign out_bit   = shift_q[FRAME_W-1];
  logic unused_ba;
  assign unused_ba = ^{ba_i[ADDR_W-3:8], ba_i[3:0], lsb_q};
`endif

  assign busy_o    = (state_q != StIdle);
  assign done_o    = (state_q == StDone);
  assign sck_o     = (state_q == StHigh);
  assign sdo_o     = sdo_q;
  assign sdo_oe_o  = mode_q[0] & ((state_q == StLow) | (state_q == StHigh));
  assign dout_oe_o = rd_en;

  always_comb begin
    status    = '0;
    status[0] = busy_o;
    status[1] = sticky_q;
`ifdef SERSEQ_LSB_FIRST_EN
    status[2] = lsb_q;
`endif
  end

  assign dout_o = !rd_en ? '0 : (ba_i[4] ? status : rx_q);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    shift_d  = shift_q;
    rx_d     = rx_q;
    bit_d    = bit_q;
    half_d   = half_q;
    sticky_d = sticky_q;
    sdo_d    = sdo_q;
    lsb_d    = lsb_q;

    if (rd_en && ba_i[4]) begin
      sticky_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          mode_d  = ba_i[5:4];
          shift_d = din_i;
          bit_d   = BitLast;
          lsb_d   = lsb_req;
        end
      end
      StLoad: begin
        sdo_d   = out_bit;
        half_d  = '0;
        state_d = StLow;
      end
      StLow: begin
        if (half_q == HalfLast) begin
          half_d  = '0;
          shift_d = shift_nxt;
          state_d = StHigh;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      StHigh: begin
        if (half_q == HalfLast) begin
          half_d = '0;
          if (bit_q == '0) begin
            state_d = StDone;
          end else begin
            // Shifter already advanced on the sampling edge; its head is the next bit.
            bit_d   = bit_q - 1'b1;
            sdo_d   = out_bit;
            state_d = StLow;
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      StDone: begin
        sdo_d    = 1'b0;
        sticky_d = 1'b1;
        if (mode_q[1]) begin
          rx_d = shift_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      sdo_d   = 1'b0;
      rx_d    = rx_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      mode_q   <= 2'b00;
      shift_q  <= '0;
      rx_q     <= '0;
      bit_q    <= '0;
      half_q   <= '0;
      sticky_q <= 1'b0;
      sdo_q    <= 1'b0;
      lsb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      shift_q  <= shift_d;
      rx_q     <= rx_d;
      bit_q    <= bit_d;
      half_q   <= half_d;
      sticky_q <= sticky_d;
      sdo_q    <= sdo_d;
      lsb_q    <= lsb_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_sequencer.sv
// Directed self-checking bench for serial_frame_sequencer with FRAME_W=8, CLK_DIV=2.
module tb_serial_frame_sequencer;
  localparam int unsigned AW = 14;
  localparam int unsigned FW = 8;
  localparam int unsigned CD = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sser;
  logic [AW-1:0] ba;
  logic          br_w;
  logic [FW-1:0] din;
  logic [FW-1:0] dout;
  logic          dout_oe, busy, done, sck, sdo, sdo_oe, sdi;

  int checks = 0;
  int errors = 0;
  int sck_rises = 0;
  int oe_rises = 0;
  int done_cnt = 0;
  int frame_base = 0;
  logic [7:0] sdo_seq = 8'h00;
  logic [7:0] rx_pat = 8'h00;

  always #5 clk = ~clk;

  serial_frame_sequencer #(
    .ADDR_W (AW),
    .SEL_HI (2'b01),
    .FRAME_W(FW),
    .CLK_DIV(CD)
  ) u_dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .sser_i   (sser),
    .ba_i     (ba),
    .br_w_i   (br_w),
    .din_i    (din),
    .dout_o   (dout),
    .dout_oe_o(dout_oe),
    .busy_o   (busy),
    .done_o   (done),
    .sck_o    (sck),
    .sdo_o    (sdo),
    .sdo_oe_o (sdo_oe),
    .sdi_i    (sdi)
  );

  always @(posedge sck) begin
    sck_rises <= sck_rises + 1;
    sdo_seq   <= {sdo_seq[6:0], sdo};
    if (sdo_oe) oe_rises <= oe_rises + 1;
  end

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  // Serial device model: presents pattern MSB-first, advancing after each sck rise.
  always_comb begin
    if ((sck_rises - frame_base) < 8) sdi = rx_pat[7 - (sck_rises - frame_base)];
    else sdi = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic s, input logic [AW-1:0] a);
    @(negedge clk);
    sser = s;
    ba   = a;
    br_w = 1'b0;
    @(negedge clk);
    sser = 1'b1;
    br_w = 1'b1;
    ba   = '0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [FW-1:0] d, output logic oe);
    @(negedge clk);
    sser = 1'b0;
    ba   = a;
    br_w = 1'b1;
    #1;
    d  = dout;
    oe = dout_oe;
    @(negedge clk);
    sser = 1'b1;
    ba   = '0;
  endtask

  task automatic start_frame(input logic [AW-1:0] a, input logic [7:0] d, input logic [7:0] pat);
    din        = d;
    rx_pat     = pat;
    frame_base = sck_rises;
    bus_write(1'b0, a);
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [FW-1:0] rd;
    logic          oe;
    int            n, oe0, d0;

    sser  = 1'b1;
    br_w  = 1'b1;
    ba    = '0;
    din   = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_sck", sck, 0);
    check_eq("rst_sdo", sdo, 0);
    check_eq("rst_sdo_oe", sdo_oe, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    rst_n = 1'b1;
    check_eq("idle_dout", dout, 0);
    check_eq("idle_dout_oe", dout_oe, 0);
    bus_read(14'h1010, rd, oe);
    check_eq("rst_status", rd, 8'h00);
    check_eq("rst_status_oe", oe, 1);
    bus_read(14'h1000, rd, oe);
    check_eq("rst_rx", rd, 8'h00);

    // TX frame
    oe0 = oe_rises;
    start_frame(14'h1090, 8'hA5, 8'h00);
    wait_done(n);
    check_eq("tx_latency", n, 34);
    check_eq("tx_sdo_seq", sdo_seq, 8'hA5);
    check_eq("tx_rises", sck_rises - frame_base, 8);
    check_eq("tx_oe_rises", oe_rises - oe0, 8);
    @(negedge clk);
    check_eq("tx_end_busy", busy, 0);
    check_eq("tx_end_oe", sdo_oe, 0);
    check_eq("tx_end_sck", sck, 0);
    bus_read(14'h1000, rd, oe);
    check_eq("tx_rx_unchanged", rd, 8'h00);
    bus_read(14'h1010, rd, oe);
    check_eq("tx_status", rd, 8'h02);

    // RX frame
    oe0 = oe_rises;
    start_frame(14'h10A0, 8'h00, 8'h3C);
    wait_done(n);
    check_eq("rx_latency", n, 34);
    check_eq("rx_oe_rises", oe_rises - oe0, 0);
    bus_read(14'h1000, rd, oe);
    check_eq("rx_data", rd, 8'h3C);
    bus_read(14'h1010, rd, oe);
    check_eq("rx_status", rd, 8'h02);

    // XCHG frame with status reads
    start_frame(14'h10B0, 8'hFF, 8'h81);
    repeat (5) @(negedge clk);
    check_eq("xchg_mid_oe", sdo_oe, 1);
    bus_read(14'h1010, rd, oe);
    check_eq("xchg_mid_status", rd, 8'h01);
    wait_done(n);
    check_eq("xchg_done", done, 1);
    bus_read(14'h1010, rd, oe);
    check_eq("xchg_status_after", rd, 8'h02);
    bus_read(14'h1010, rd, oe);
    check_eq("xchg_status_cleared", rd, 8'h00);
    bus_read(14'h1000, rd, oe);
    check_eq("xchg_rx", rd, 8'h81);
    check_eq("xchg_sdo_seq", sdo_seq, 8'hFF);
    check_eq("done_pulses", done_cnt, 3);

    // Abort after three sck rises
    start_frame(14'h1090, 8'hA5, 8'h00);
    d0 = done_cnt;
    n  = 0;
    while ((sck_rises - frame_base) < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("abort_pre_rises", sck_rises - frame_base, 3);
    bus_write(1'b0, 14'h1040);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_sck", sck, 0);
    check_eq("abort_oe", sdo_oe, 0);
    repeat (40) @(negedge clk);
    check_eq("abort_no_done", done_cnt, d0);
    check_eq("abort_rises", sck_rises - frame_base, 3);
    bus_read(14'h1000, rd, oe);
    check_eq("abort_rx", rd, 8'h81);

    // Bad decode: sser high, then wrong window
    bus_write(1'b1, 14'h1090);
    check_eq("sser_high_busy", busy, 0);
    bus_write(1'b0, 14'h0090);
    check_eq("bad_window_busy", busy, 0);

    // Start while busy (as RX) is ignored
    oe0 = oe_rises;
    start_frame(14'h1090, 8'h5A, 8'hFF);
    repeat (6) @(negedge clk);
    bus_write(1'b0, 14'h10A0);
    wait_done(n);
    check_eq("restart_done", done, 1);
    check_eq("restart_rises", sck_rises - frame_base, 8);
    check_eq("restart_sdo_seq", sdo_seq, 8'h5A);
    check_eq("restart_oe_rises", oe_rises - oe0, 8);
    bus_read(14'h1000, rd, oe);
    check_eq("restart_rx", rd, 8'h81);

    // Reset mid-frame truncates with no done
    start_frame(14'h10B0, 8'h33, 8'hC3);
    repeat (8) @(negedge clk);
    d0    = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_sck", sck, 0);
    repeat (40) @(negedge clk);
    check_eq("midrst_no_done", done_cnt, d0);
    bus_read(14'h1000, rd, oe);
    check_eq("midrst_rx", rd, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
